// File: rtl/pm_clk_pkg.sv
// rtl/pm_clk_pkg.sv - shared state encoding and default rates for the PLL lock / clock-enable block
package pm_clk_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        WAIT = 2'd1,
        RUN  = 2'd2
    } pm_state_t;

    localparam int unsigned DEF_CLK_HZ = 4000000;
    localparam int unsigned DEF_RTC_HZ = 32768;

endpackage

// File: rtl/pll_lock_ce_gen_if.sv
// rtl/pll_lock_ce_gen_if.sv - lock input, core reset and clock-enable outputs of pll_lock_ce_gen
interface pll_lock_ce_gen_if;

    logic pll_locked;
    logic sys_reset;
    logic ce_div2;
    logic ce_rtc;
    logic ce_sec;
    logic lock_lost;

    modport master (
        input  pll_locked,
        output sys_reset,
        output ce_div2,
        output ce_rtc,
        output ce_sec,
        output lock_lost
    );

    modport slave (
        output pll_locked,
        input  sys_reset,
        input  ce_div2,
        input  ce_rtc,
        input  ce_sec,
        input  lock_lost
    );

endinterface

// File: rtl/pm_sync2.sv
// rtl/pm_sync2.sv - generic two-flop synchronizer, asynchronous active-high reset to 0
module pm_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_ce_gen.sv
// rtl/pll_lock_ce_gen.sv - qualifies PLL lock, releases core reset, generates div2 / RTC / 1 Hz enables
module pll_lock_ce_gen
    import pm_clk_pkg::*;
#(
    parameter int unsigned CLK_HZ      = DEF_CLK_HZ,
    parameter int unsigned RTC_HZ      = DEF_RTC_HZ,
    parameter int unsigned LOCK_STABLE = 1024,
    parameter int unsigned SEC_DIV     = 32768,
    parameter int unsigned ACC_W       = 24
) (
    input  logic               clk,
    input  logic               rst,
    pll_lock_ce_gen_if.master  bus
);

    localparam int unsigned STAB_W = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
    localparam int unsigned SEC_W  = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;

    localparam logic [ACC_W-1:0]  RTC_INC   = ACC_W'(RTC_HZ);
    localparam logic [ACC_W-1:0]  CLK_LIM   = ACC_W'(CLK_HZ);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE - 1);
    localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(SEC_DIV - 1);

    pm_state_t         state;
    logic              lk_s;
    logic [STAB_W-1:0] stab_cnt;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_nxt;
    logic [SEC_W-1:0]  sec_cnt;
    logic              div_tgl;
    logic              sys_reset_q;
    logic              ce_div2_q;
    logic              ce_rtc_q;
    logic              ce_sec_q;
    logic              lock_lost_q;

    pm_sync2 u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.pll_locked),
        .q   (lk_s)
    );

    assign acc_nxt = acc + RTC_INC;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HOLD;
            stab_cnt    <= '0;
            acc         <= '0;
            sec_cnt     <= '0;
            div_tgl     <= 1'b0;
            sys_reset_q <= 1'b1;
            ce_div2_q   <= 1'b0;
            ce_rtc_q    <= 1'b0;
            ce_sec_q    <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            ce_div2_q <= 1'b0;
            ce_rtc_q  <= 1'b0;
            ce_sec_q  <= 1'b0;
            // Enable generators restart from zero on every entry into RUN.
            if (state != RUN || !lk_s) begin
                acc     <= '0;
                sec_cnt <= '0;
                div_tgl <= 1'b0;
            end
            case (state)
                HOLD: begin
                    sys_reset_q <= 1'b1;
                    stab_cnt    <= '0;
                    if (lk_s) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!lk_s) begin
                        state <= HOLD;
                    end else if (stab_cnt == STAB_LAST) begin
                        state       <= RUN;
                        sys_reset_q <= 1'b0;
                    end else begin
                        stab_cnt <= stab_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!lk_s) begin
                        state       <= HOLD;
                        sys_reset_q <= 1'b1;
                        lock_lost_q <= 1'b1;
                    end else begin
                        div_tgl   <= ~div_tgl;
                        ce_div2_q <= ~div_tgl;
                        // Subtracting CLK_HZ keeps the remainder, so the average rate never drifts.
                        if (acc_nxt >= CLK_LIM) begin
                            acc      <= acc_nxt - CLK_LIM;
                            ce_rtc_q <= 1'b1;
                            if (sec_cnt == SEC_LAST) begin
                                sec_cnt  <= '0;
                                ce_sec_q <= 1'b1;
                            end else begin
                                sec_cnt <= sec_cnt + 1'b1;
                            end
                        end else begin
                            acc <= acc_nxt;
                        end
                    end
                end
                default: begin
                    state       <= HOLD;
                    sys_reset_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.sys_reset = sys_reset_q;
    assign bus.ce_div2   = ce_div2_q;
    assign bus.ce_rtc    = ce_rtc_q;
    assign bus.ce_sec    = ce_sec_q;
    assign bus.lock_lost = lock_lost_q;

endmodule

// File: tb/tb_pll_lock_ce_gen.sv
// tb/tb_pll_lock_ce_gen.sv - self-checking bench for pll_lock_ce_gen with small rate parameters
module tb_pll_lock_ce_gen;

    localparam int CLK_HZ      = 100;
    localparam int RTC_HZ      = 30;
    localparam int LOCK_STABLE = 8;
    localparam int SEC_DIV     = 4;
    localparam int ACC_W       = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pll_lock_ce_gen_if bus ();

    pll_lock_ce_gen #(
        .CLK_HZ      (CLK_HZ),
        .RTC_HZ      (RTC_HZ),
        .LOCK_STABLE (LOCK_STABLE),
        .SEC_DIV     (SEC_DIV),
        .ACC_W       (ACC_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: lock must be seen on LOCK_STABLE+1 consecutive edges (one
    // to leave HOLD, LOCK_STABLE qualifying); in RUN the n-th cycle's enables follow
    // directly from floor(n*RTC_HZ/CLK_HZ).
    logic m1 = 1'b0, m2 = 1'b0;
    logic m_run = 1'b0, m_lost = 1'b0;
    logic e_div2 = 1'b0, e_rtc = 1'b0, e_sec = 1'b0;
    int   streak = 0, n = 0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m1 = 1'b0; m2 = 1'b0; m_run = 1'b0; m_lost = 1'b0;
            e_div2 = 1'b0; e_rtc = 1'b0; e_sec = 1'b0;
            streak = 0; n = 0;
        end else begin
            e_div2 = 1'b0; e_rtc = 1'b0; e_sec = 1'b0;
            if (m_run && m2) begin
                n++;
                e_div2 = (n % 2) == 1;
                e_rtc  = (n * RTC_HZ / CLK_HZ) != ((n - 1) * RTC_HZ / CLK_HZ);
                e_sec  = e_rtc && (((n * RTC_HZ / CLK_HZ) % SEC_DIV) == 0);
            end else if (m_run) begin
                m_run = 1'b0; m_lost = 1'b1; streak = 0;
            end else begin
                streak = m2 ? streak + 1 : 0;
                if (streak == LOCK_STABLE + 1) begin
                    m_run = 1'b1; n = 0;
                end
            end
            m2 = m1;
            m1 = bus.pll_locked;
        end
    end

    logic cmp_en = 1'b0;
    int cyc = 0, rtc_cnt = 0, sec_cnt = 0, div_cnt = 0;
    int last_rtc = -1, gap_bad = 0, sec_bad = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (!rst && cmp_en) begin
            chk1("cmp_sys_reset", bus.sys_reset, !m_run);
            chk1("cmp_ce_div2", bus.ce_div2, e_div2);
            chk1("cmp_ce_rtc", bus.ce_rtc, e_rtc);
            chk1("cmp_ce_sec", bus.ce_sec, e_sec);
            chk1("cmp_lock_lost", bus.lock_lost, m_lost);
        end
        if (bus.ce_rtc) begin
            rtc_cnt++;
            if (last_rtc >= 0 && (cyc - last_rtc < 3 || cyc - last_rtc > 4)) gap_bad++;
            last_rtc = cyc;
        end
        if (bus.ce_sec) begin
            sec_cnt++;
            if (!bus.ce_rtc) sec_bad++;
        end
        if (bus.ce_div2) div_cnt++;
    end

    task automatic wait_release(input string name, output int k);
        k = 0;
        while (bus.sys_reset !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) chki({name, "_timeout"}, k, -1);
    endtask

    task automatic wait_rtc(input string name, output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.ce_rtc !== 1'b1 && k < 50);
        if (k >= 50) chki({name, "_timeout"}, k, -1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    int k, r0, s0, p0;

    initial begin
        bus.pll_locked = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk1("rst_sys_reset", bus.sys_reset, 1'b1);
        chk1("rst_ce_div2", bus.ce_div2, 1'b0);
        chk1("rst_ce_rtc", bus.ce_rtc, 1'b0);
        chk1("rst_ce_sec", bus.ce_sec, 1'b0);
        chk1("rst_lock_lost", bus.lock_lost, 1'b0);
        rst = 1'b0;
        cmp_en = 1'b1;

        // Lock held low: no release, no enables.
        p0 = rtc_cnt + sec_cnt + div_cnt;
        repeat (40) @(negedge clk);
        chk1("stuck_sys_reset", bus.sys_reset, 1'b1);
        chki("stuck_pulses", rtc_cnt + sec_cnt + div_cnt - p0, 0);

        // Clean lock: release after 2 sync + 1 HOLD + 8 WAIT edges.
        bus.pll_locked = 1'b1;
        wait_release("release", k);
        chki("release_latency", k, 11);

        r0 = rtc_cnt; s0 = sec_cnt; last_rtc = -1; gap_bad = 0; sec_bad = 0;
        @(negedge clk);
        chk1("first_div2", bus.ce_div2, 1'b1);
        repeat (999) @(negedge clk);
        chki("rtc_in_1000", rtc_cnt - r0, 300);
        chki("sec_in_1000", sec_cnt - s0, 75);
        chki("rtc_gap_bad", gap_bad, 0);
        chki("sec_not_on_rtc", sec_bad, 0);

        // Lock drop in RUN: two sync edges plus the FSM edge.
        bus.pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        chk1("drop_still_run", bus.sys_reset, 1'b0);
        @(negedge clk);
        chk1("drop_sys_reset", bus.sys_reset, 1'b1);
        chk1("drop_lock_lost", bus.lock_lost, 1'b1);
        chk1("drop_ce_div2", bus.ce_div2, 1'b0);
        chk1("drop_ce_rtc", bus.ce_rtc, 1'b0);
        repeat (3) @(negedge clk);
        bus.pll_locked = 1'b1;
        wait_release("relock", k);
        chki("relock_latency", k, 11);
        chk1("relock_lock_lost", bus.lock_lost, 1'b1);
        wait_rtc("relock_rtc", k);
        chki("relock_first_rtc", k, 4);

        // One-cycle glitch while qualifying (stab_cnt=5) forces a full restart.
        bus.pll_locked = 1'b0;
        repeat (6) @(negedge clk);
        bus.pll_locked = 1'b1;
        repeat (8) @(negedge clk);
        bus.pll_locked = 1'b0;
        @(negedge clk);
        bus.pll_locked = 1'b1;
        wait_release("glitch", k);
        chki("glitch_latency", 9 + k, 20);

        // Asynchronous reset between edges while running.
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk1("arst_sys_reset", bus.sys_reset, 1'b1);
        chk1("arst_ce_div2", bus.ce_div2, 1'b0);
        chk1("arst_ce_rtc", bus.ce_rtc, 1'b0);
        chk1("arst_ce_sec", bus.ce_sec, 1'b0);
        chk1("arst_lock_lost", bus.lock_lost, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        wait_release("post_rst", k);
        chki("post_rst_latency", k, 11);
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
